// File: rtl/pipelined_signed_addsub.sv
// Pipelined two's-complement add/sub: carry chain cut into STAGES chunks,
// per-result overflow, optional saturation, sticky flag and event counter.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   arg_vld        operands valid (accepted every cycle)
//   sub            0: a + b, 1: a - b
//   a, b           signed operands
//   clr_ovf        sync clear of ovf_sticky / ovf_count
//   res_vld        result valid, STAGES cycles after sampling
//   res            wrapped or saturated result (holds while res_vld=0)
//   overflow       overflow of the presented result
//   ovf_sticky     any valid overflow since last clear
//   ovf_count      valid overflows since last clear, saturating
module pipelined_signed_addsub #(
    parameter int WIDTH    = 8,
    parameter int STAGES   = 2,
    parameter int SATURATE = 0,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arg_vld,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_ovf,
    output logic             res_vld,
    output logic [WIDTH-1:0] res,
    output logic             overflow,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int CH = WIDTH / STAGES;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Stage k works on chunk k. The x word carries finished sum chunks
    // below chunk k and untouched a bits above; the y word keeps only
    // the b_eff bits that are still to be consumed.
    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        logic                  v_i;
        logic [WIDTH-1:0]      x_i;
        logic [WIDTH-1:k*CH]   y_i;
        logic                  c_i;
        logic [CH:0]           part;
        logic [WIDTH-1:0]      x_o;

        if (k == 0) begin : g_in
            assign v_i = arg_vld;
            assign x_i = a;
            assign y_i = sub ? ~b : b;
            assign c_i = sub;
        end else begin : g_in
            assign v_i = g_stage[k-1].g_reg.v_q;
            assign x_i = g_stage[k-1].g_reg.x_q;
            assign y_i = g_stage[k-1].g_reg.y_q;
            assign c_i = g_stage[k-1].g_reg.c_q;
        end

        assign part = {1'b0, x_i[k*CH +: CH]}
                    + {1'b0, y_i[k*CH +: CH]}
                    + {{CH{1'b0}}, c_i};

        always_comb begin
            x_o = x_i;
            x_o[k*CH +: CH] = part[CH-1:0];
        end

        if (k < STAGES - 1) begin : g_reg
            logic                      v_q;
            logic [WIDTH-1:0]          x_q;
            logic [WIDTH-1:(k+1)*CH]   y_q;
            logic                      c_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    x_q <= '0;
                    y_q <= '0;
                    c_q <= 1'b0;
                end else begin
                    v_q <= v_i;
                    if (v_i) begin
                        x_q <= x_o;
                        y_q <= y_i[WIDTH-1:(k+1)*CH];
                        c_q <= part[CH];
                    end
                end
            end
        end else begin : g_out
            logic             ovf_c;
            logic [WIDTH-1:0] res_c;

            // carry into MSB recovered as a ^ b ^ sum at the MSB
            assign ovf_c = part[CH]
                         ^ (x_i[WIDTH-1] ^ y_i[WIDTH-1] ^ x_o[WIDTH-1]);

            // x_i MSB is still the original a sign bit here
            if (SATURATE != 0) begin : g_sat
                assign res_c = !ovf_c ? x_o :
                               (x_i[WIDTH-1] ? MAX_NEG : MAX_POS);
            end else begin : g_wrap
                assign res_c = x_o;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_vld  <= 1'b0;
                    res      <= '0;
                    overflow <= 1'b0;
                end else begin
                    res_vld <= v_i;
                    if (v_i) begin
                        res      <= res_c;
                        overflow <= ovf_c;
                    end
                end
            end
        end
    end

    logic ovf_ev;
    assign ovf_ev = res_vld & overflow;

    // a fresh event beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end else if (ovf_ev) begin
            ovf_sticky <= 1'b1;
            if (clr_ovf) begin
                ovf_count <= CNT_W'(1);
            end else if (ovf_count != {CNT_W{1'b1}}) begin
                ovf_count <= ovf_count + CNT_W'(1);
            end
        end else if (clr_ovf) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end
    end

endmodule

// File: tb/tb_pipelined_signed_addsub.sv
// Scoreboard bench for pipelined_signed_addsub: 4-bit wrap and
// saturating instances plus a 16-bit 4-stage instance.
module tb_pipelined_signed_addsub;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        arg_vld4, sub4, clr4;
    logic [3:0]  a4, b4;
    logic        arg_vld16, sub16, clr16;
    logic [15:0] a16, b16;

    logic        a_vld, a_ovf, a_sticky;
    logic [3:0]  a_res;
    logic [7:0]  a_count;
    logic        b_vld, b_ovf, b_sticky;
    logic [3:0]  b_res;
    logic [1:0]  b_count;
    logic        c_vld, c_ovf, c_sticky;
    logic [15:0] c_res;
    logic [7:0]  c_count;

    pipelined_signed_addsub #(
        .WIDTH(4), .STAGES(2), .SATURATE(0), .CNT_W(8)
    ) u_wrap (
        .clk(clk), .rst_n(rst_n), .arg_vld(arg_vld4), .sub(sub4),
        .a(a4), .b(b4), .clr_ovf(clr4), .res_vld(a_vld), .res(a_res),
        .overflow(a_ovf), .ovf_sticky(a_sticky), .ovf_count(a_count)
    );

    pipelined_signed_addsub #(
        .WIDTH(4), .STAGES(2), .SATURATE(1), .CNT_W(2)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .arg_vld(arg_vld4), .sub(sub4),
        .a(a4), .b(b4), .clr_ovf(clr4), .res_vld(b_vld), .res(b_res),
        .overflow(b_ovf), .ovf_sticky(b_sticky), .ovf_count(b_count)
    );

    pipelined_signed_addsub #(
        .WIDTH(16), .STAGES(4), .SATURATE(0), .CNT_W(8)
    ) u_wide (
        .clk(clk), .rst_n(rst_n), .arg_vld(arg_vld16), .sub(sub16),
        .a(a16), .b(b16), .clr_ovf(clr16), .res_vld(c_vld), .res(c_res),
        .overflow(c_ovf), .ovf_sticky(c_sticky), .ovf_count(c_count)
    );

    typedef struct {
        longint res;
        bit     ovf;
        int     tag;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   c_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input longint obs,
                            input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // reference: exact integer sum, range test, clamp or wrap
    function automatic exp_t model(input int w, input bit sat,
                                   input longint av, input longint bv,
                                   input bit s, input int tag);
        exp_t   e;
        longint mx, mn, r;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -mx - 1;
        r = s ? av - bv : av + bv;
        e.ovf = (r > mx) || (r < mn);
        if (sat && e.ovf) r = (r > mx) ? mx : mn;
        e.res = r & ((longint'(1) <<< w) - 1);
        e.tag = tag;
        return e;
    endfunction

    task automatic op4(input bit v, input int av, input int bv,
                       input bit s);
        arg_vld4 = v;
        a4 = av[3:0];
        b4 = bv[3:0];
        sub4 = s;
        if (v) begin
            qa.push_back(model(4, 0, av, bv, s, cyc + 1));
            qb.push_back(model(4, 1, av, bv, s, cyc + 1));
        end
        @(posedge clk);
        #1;
        arg_vld4 = 1'b0;
    endtask

    task automatic op16(input bit v, input logic [15:0] av,
                        input logic [15:0] bv, input bit s);
        exp_t e;
        arg_vld16 = v;
        a16 = av;
        b16 = bv;
        sub16 = s;
        if (v) begin
            e = model(16, 0, longint'($signed(av)),
                      longint'($signed(bv)), s, cyc + 1);
            if (e.ovf && c_cnt < 255) c_cnt++;
            qc.push_back(e);
        end
        @(posedge clk);
        #1;
        arg_vld16 = 1'b0;
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_vld) begin
            if (qa.size() == 0) begin
                check_eq("a_spurious", 1, 0);
            end else begin
                e = qa.pop_front();
                check_eq("a_res", a_res, e.res);
                check_eq("a_ovf", a_ovf, e.ovf);
                check_eq("a_lat", cyc - e.tag, 1);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_vld) begin
            if (qb.size() == 0) begin
                check_eq("b_spurious", 1, 0);
            end else begin
                e = qb.pop_front();
                check_eq("b_res", b_res, e.res);
                check_eq("b_ovf", b_ovf, e.ovf);
                check_eq("b_lat", cyc - e.tag, 1);
            end
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (c_vld) begin
            if (qc.size() == 0) begin
                check_eq("c_spurious", 1, 0);
            end else begin
                e = qc.pop_front();
                check_eq("c_res", c_res, e.res);
                check_eq("c_ovf", c_ovf, e.ovf);
                check_eq("c_lat", cyc - e.tag, 3);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        arg_vld4 = 0; sub4 = 0; clr4 = 0; a4 = '0; b4 = '0;
        arg_vld16 = 0; sub16 = 0; clr16 = 0; a16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_a_vld", a_vld, 0);
        check_eq("rst_a_res", a_res, 0);
        check_eq("rst_a_cnt", a_count, 0);
        check_eq("rst_c_vld", c_vld, 0);
        check_eq("rst_c_stk", c_sticky, 0);
        rst_n = 1'b1;

        op4(1, 4, 7, 0);
        op4(0, 0, 0, 0);
        op4(0, 0, 0, 0);
        check_eq("a_stk_1", a_sticky, 1);
        check_eq("a_cnt_1", a_count, 1);
        check_eq("b_cnt_1", b_count, 1);

        op4(1, -4, -7, 0);
        op4(1, -4, -4, 0);
        op4(1, 3, -6, 1);
        op4(1, -8, 1, 1);
        op4(1, 0, -8, 1);
        op4(1, -1, -8, 1);
        repeat (3) op4(0, 0, 0, 0);
        check_eq("a_cnt_5", a_count, 5);
        check_eq("b_cnt_sat", b_count, 3);

        op4(1, 4, 7, 0);
        op4(0, 0, 0, 0);
        clr4 = 1'b1;
        op4(0, 0, 0, 0);
        clr4 = 1'b0;
        check_eq("clr_ev_stk", a_sticky, 1);
        check_eq("clr_ev_cnt", a_count, 1);
        check_eq("clr_ev_bcnt", b_count, 1);
        check_eq("a_hold_vld", a_vld, 0);
        check_eq("a_hold_res", a_res, 11);
        check_eq("b_hold_res", b_res, 7);
        clr4 = 1'b1;
        op4(0, 0, 0, 0);
        clr4 = 1'b0;
        check_eq("clr_stk", a_sticky, 0);
        check_eq("clr_cnt", a_count, 0);

        check_eq("c_cnt_0", c_count, 0);
        for (int i = 0; i < 200; i++) begin
            while ($urandom_range(0, 3) == 0) op16(0, '0, '0, 0);
            op16(1, 16'($urandom), 16'($urandom), 1'($urandom));
        end
        repeat (6) op16(0, '0, '0, 0);
        check_eq("c_cnt_model", c_count, c_cnt);
        check_eq("c_drain", qc.size(), 0);
        check_eq("a_drain", qa.size(), 0);
        check_eq("b_drain", qb.size(), 0);

        op16(1, 16'h7fff, 16'h0001, 0);
        op16(1, 16'h8000, 16'h0001, 1);
        op16(1, 16'h1234, 16'h4321, 0);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_vld", c_vld, 0);
        check_eq("mid_rst_res", c_res, 0);
        check_eq("mid_rst_ovf", c_ovf, 0);
        check_eq("mid_rst_cnt", c_count, 0);
        check_eq("mid_rst_stk", c_sticky, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        qc.delete();
        c_cnt = 0;
        repeat (8) op16(0, '0, '0, 0);
        check_eq("post_rst_cnt", c_count, 0);
        check_eq("post_rst_res", c_res, 0);
        check_eq("post_rst_q", qc.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_signed_addsub.md
# pipelined_signed_addsub

Parametrised, pipelined two's-complement adder/subtractor with per-result overflow detection, optional saturation, and a sticky overflow flag plus saturating event counter. The carry chain is split across `STAGES` register stages, so wide operands close timing at one result per clock. It sits in the arithmetic datapath as the streaming successor to the 4-bit combinational signed adder with overflow.

## Interface
- `WIDTH`, 8: operand/result width in bits; must be a multiple of `STAGES`, minimum 2.
- `STAGES`, 2: pipeline depth; the carry chain is cut into `STAGES` chunks of `WIDTH/STAGES` bits; minimum 1.
- `SATURATE`, 0: 0 = wrap-around result on overflow; 1 = clamp to most-positive/most-negative.
- `CNT_W`, 8: width of the overflow event counter.

- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `arg_vld`  in  1  operands valid this cycle; no backpressure, accepted every cycle.
- `sub`  in  1  0 = a + b, 1 = a − b; sampled with operands.
- `a`  in  WIDTH  signed operand.
- `b`  in  WIDTH  signed operand.
- `clr_ovf`  in  1  synchronous clear of `ovf_sticky` and `ovf_count`.
- `res_vld`  out  1  result valid.
- `res`  out  WIDTH  signed result (wrapped or saturated).
- `overflow`  out  1  overflow of the result currently presented; qualified by `res_vld`.
- `ovf_sticky`  out  1  set by any valid overflowing result since last clear.
- `ovf_count`  out  CNT_W  number of valid overflowing results since last clear, saturates at all-ones.

## Operation
- Subtraction is a + ~b + 1: `b` inverted and carry-in forced to 1 in stage 0 when `sub`=1.
- Stage k (0..STAGES−1) adds chunk k of the effective operands with the carry registered from stage k−1; completed lower chunks and not-yet-used upper operand chunks are delayed alongside.
- Valid bit travels with data; data registers of a stage load only when that stage's incoming valid is 1, otherwise hold.
- Overflow computed in the final stage: carry into MSB XOR carry out of MSB (equivalently: effective operand signs equal and result sign differs).
- `SATURATE`=1 and overflow: `res` = {0,1…1} if a's sign bit is 0, else {1,0…0}; `overflow` still reported 1.
- `res`/`overflow` hold last valid values while `res_vld`=0.
- `ovf_sticky` sets when `res_vld`&`overflow`; `ovf_count` increments in the same cycle unless all-ones.
- `clr_ovf` and a new overflow in the same cycle: sticky ends 1, counter ends 1 (event wins over clear).
- No internal state machine beyond the valid shift chain; throughput one operation per cycle, no bubbles inserted.

## Timing
- Latency exactly `STAGES` cycles: operands sampled at edge N appear with `res_vld`=1 after edge N+STAGES−1... i.e. visible in the cycle following edge N+STAGES−1, `STAGES` edges after sampling edge inclusive.
- `STAGES`=1: a single register stage, result visible one cycle after sampling.
- Back-to-back `arg_vld` yields back-to-back `res_vld` in order; gaps in `arg_vld` reproduced exactly.
- Reset (`rst_n`=0, asynchronous assert): all valid bits, data registers, `res`, `overflow`, `ovf_sticky`, `ovf_count` go to 0 immediately; in-flight operations are discarded, not completed. Release is synchronised by the integrating design.
- `clr_ovf` takes effect at the next rising edge; outputs from the pipeline are unaffected.

## Test plan
- WIDTH=4, STAGES=2, SATURATE=0: a=4,b=7,sub=0 -> two cycles later `res`=4'b1011 (−5), `overflow`=1, `ovf_sticky`=1, `ovf_count`=1.
- Same config, SATURATE=1: a=4,b=7 -> `res`=7, overflow=1; a=−4,b=−7 -> `res`=−8, overflow=1; a=−4,b=−4 -> `res`=−8, overflow=0.
- Subtract, WIDTH=4: a=3,b=−6,sub=1 -> overflow=1 (wrap `res`=−7); a=−8,b=1 -> overflow=1; a=0,b=−8 -> overflow=1; a=−1,b=−8 -> `res`=7, overflow=0.
- WIDTH=16, STAGES=4, 200 back-to-back random operands with random `sub` and gaps in `arg_vld` -> every `res`/`overflow` matches reference model, `res_vld` pattern equals `arg_vld` delayed 4 cycles, `ovf_count` equals model count.
- Assert `rst_n`=0 for one cycle while three operations are in flight -> `res_vld` drops immediately, none of the three ever emerges, all outputs 0, counter 0.
- `clr_ovf`=1 in the same cycle as a valid overflow result with `ovf_count`=5 -> next cycle `ovf_sticky`=1, `ovf_count`=1; CNT_W=2 with 5 overflows -> `ovf_count`=3.
